// File: rtl/sort_pkg.sv
// Shared types and constants for the 5-input sorter front end (sort_loader).
package sort_pkg;
    localparam int W = 8;
    localparam int N = 5;

    typedef logic [W-1:0] elem_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SETUP = 2'd1,
        FIRE  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Width of a down-counter able to hold the largest of the three phase lengths.
    function automatic int cnt_width(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        m = (z > m) ? z : m;
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/sort_loader_if.sv
// Valid/ready byte-stream link feeding the sort_loader.
interface sort_loader_if;
    import sort_pkg::*;
    elem_t in_data;
    logic  in_valid;
    logic  in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sort_down_counter.sv
// Loadable down-counter with a registered zero flag; saturates at zero.
module sort_down_counter #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);
    logic [CW-1:0] value_r;
    logic [CW-1:0] value_next_s;
    logic          zero_r;

    // Next count: load has priority, decrement stops at zero.
    always_comb begin
        value_next_s = value_r;
        if (load) begin
            value_next_s = load_val;
        end else if (dec && (value_r != {CW{1'b0}})) begin
            value_next_s = value_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            value_next_s = value_r;
        end
    end

    // Count register and zero flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= {CW{1'b0}};
            zero_r  <= 1'b1;
        end else begin
            value_r <= value_next_s;
            zero_r  <= (value_next_s == {CW{1'b0}});
        end
    end

    assign zero = zero_r;
endmodule

// File: rtl/sort_loader.sv
// Collects N serial beats into a frame, presents it on a..e and pulses s for the sorter.
// Optional partial-frame timeout enabled by defining SORT_LOADER_TIMEOUT_EN.
module sort_loader
    import sort_pkg::*;
#(
    parameter int START_LEN = 2,
    parameter int GAP_LEN   = 6,
    parameter int TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst,
    sort_loader_if.slave        up,
    input  logic                flush,
    output elem_t               a,
    output elem_t               b,
    output elem_t               c,
    output elem_t               d,
    output elem_t               e,
    output logic                s,
    output logic                drop,
    output logic [7:0]          frame_cnt
);
    localparam int CW = cnt_width(START_LEN, GAP_LEN, TIMEOUT);
    localparam int NW = $clog2(N);

    state_t          state_r;
    logic [NW-1:0]   count_r;
    elem_t           shadow_r [0:N-1];
    elem_t           a_r, b_r, c_r, d_r, e_r;
    logic            s_r;
    logic            drop_r;
    logic [7:0]      frame_cnt_r;

    logic            accept_s;
    logic            cnt_load_s;
    logic [CW-1:0]   cnt_val_s;
    logic            cnt_dec_s;
    logic            cnt_zero_s;

    assign up.in_ready = (state_r == FILL);
    // flush beats a same-cycle beat, so the beat is simply never accepted
    assign accept_s    = up.in_valid && (state_r == FILL) && !flush;

    sort_down_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    // Phase counter control: pulse length, cool-down and (optionally) idle timeout.
    always_comb begin
        cnt_load_s = 1'b0;
        cnt_val_s  = {CW{1'b0}};
        cnt_dec_s  = 1'b0;
        case (state_r)
            FILL: begin
`ifdef SORT_LOADER_TIMEOUT_EN
                if (flush || accept_s) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = CW'(TIMEOUT - 1);
                end else if (count_r != NW'(0)) begin
                    cnt_dec_s = 1'b1;
                end else begin
                    cnt_dec_s = 1'b0;
                end
`else
                cnt_load_s = 1'b0;
`endif
            end
            SETUP: begin
                cnt_load_s = 1'b1;
                cnt_val_s  = CW'(START_LEN - 1);
            end
            FIRE: begin
                if (cnt_zero_s) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = CW'(GAP_LEN - 1);
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            GAP: begin
                cnt_dec_s = 1'b1;
            end
            default: begin
                cnt_load_s = 1'b0;
            end
        endcase
    end

    // Frame FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= FILL;
            count_r     <= NW'(0);
            for (int i = 0; i < N; i++) shadow_r[i] <= {W{1'b0}};
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            c_r         <= {W{1'b0}};
            d_r         <= {W{1'b0}};
            e_r         <= {W{1'b0}};
            s_r         <= 1'b0;
            drop_r      <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else begin
            drop_r <= 1'b0;
            case (state_r)
                FILL: begin
                    s_r <= 1'b0;
                    if (flush) begin
                        count_r <= NW'(0);
                        drop_r  <= (count_r != NW'(0));
                    end else if (accept_s) begin
                        shadow_r[count_r] <= up.in_data;
                        if (count_r == NW'(N - 1)) begin
                            a_r         <= shadow_r[0];
                            b_r         <= shadow_r[1];
                            c_r         <= shadow_r[2];
                            d_r         <= shadow_r[3];
                            e_r         <= up.in_data;
                            count_r     <= NW'(0);
                            frame_cnt_r <= frame_cnt_r + 8'd1;
                            state_r     <= SETUP;
                        end else begin
                            count_r <= count_r + NW'(1);
                        end
`ifdef SORT_LOADER_TIMEOUT_EN
                    end else if ((count_r != NW'(0)) && cnt_zero_s) begin
                        count_r <= NW'(0);
                        drop_r  <= 1'b1;
`endif
                    end else begin
                        count_r <= count_r;
                    end
                end
                SETUP: begin
                    s_r     <= 1'b1;
                    state_r <= FIRE;
                end
                FIRE: begin
                    if (cnt_zero_s) begin
                        s_r     <= 1'b0;
                        state_r <= GAP;
                    end else begin
                        s_r <= 1'b1;
                    end
                end
                GAP: begin
                    s_r <= 1'b0;
                    if (cnt_zero_s) begin
                        state_r <= FILL;
                    end else begin
                        state_r <= GAP;
                    end
                end
                default: begin
                    s_r     <= 1'b0;
                    state_r <= FILL;
                end
            endcase
        end
    end

    assign a         = a_r;
    assign b         = b_r;
    assign c         = c_r;
    assign d         = d_r;
    assign e         = e_r;
    assign s         = s_r;
    assign drop      = drop_r;
    assign frame_cnt = frame_cnt_r;
endmodule

// File: doc/sort_loader.md
Name: sort_loader

Overview:
- Upstream feeder for the 5-input byte sorter.
- Collects a serial byte stream over a valid/ready handshake into a 5-entry frame, then presents the frame in parallel on a..e.
- One cycle after the frame is stable, issues a start pulse s to the sorter.
- Holds a..e stable until the next frame commits. Blocks input during pulse and cool-down so the sorter finishes its 6-cycle output scan.

Parameters:
- W, 8, data width of each element.
- N, 5, elements per frame (fixed to sorter width; a..e ports assume 5).
- START_LEN, 2, cycles s is held high.
- GAP, 6, cool-down cycles after s falls before the next beat is accepted.
- TIMEOUT, 16, idle cycles before a partial frame is discarded (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  W  stream element.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept; beat transfers when in_valid && in_ready at rising clk.
- flush  in  1  synchronous discard of partial frame.
- a, b, c, d, e  out  W each  frame elements 1st..5th beat, registered.
- s  out  1  sorter start pulse, registered.
- drop  out  1  one-cycle pulse: partial frame discarded.
- frame_cnt  out  8  committed frames, wraps 255->0.

Behaviour:
- Reset (async, any state): state=FILL, count=0, a..e=0, s=0, drop=0, frame_cnt=0, shadow regs=0. An s pulse in progress is truncated immediately.
- in_ready = (state==FILL); combinational from state. It is 1 right after reset.
- FILL:
  - Each accepted beat stores in_data to shadow[count]; count++.
  - Beat accepted with count==N-1: a..e load shadow[0..3] plus in_data in the same edge; count->0; frame_cnt++; state->SETUP.
- SETUP (1 cycle): s=0, a..e already stable; ->FIRE.
- FIRE (START_LEN cycles): s=1; ->GAP.
- GAP (GAP cycles): s=0; ->FILL.
- Latency: 5th beat accepted at edge k; a..e valid after k; s high after edge k+1 through edge k+1+START_LEN.
- Minimum frame period: N + 1 + START_LEN + GAP cycles (14 at defaults).
- flush:
  - In FILL: count->0, shadow untouched, a..e untouched, drop=1 next cycle only if count>0.
  - flush && accepted beat in the same cycle: flush wins and the beat is discarded.
  - Ignored outside FILL.
- in_valid while not ready: data is not consumed. The source must hold the beat.
- a..e never change except at a commit edge or reset.
- Internal state/phase counters use ceil(log2(max(START_LEN,GAP,TIMEOUT)+1)) bits; no overflow.

Optional Feature:
- SORT_LOADER_TIMEOUT_EN
- Defined:
  - In FILL with count>0, an idle counter increments each cycle with no accepted beat and resets on accept.
  - Reaching TIMEOUT: count->0, drop=1 for one cycle, idle->0.
  - flush also clears idle.
- Undefined: a partial frame is held indefinitely; drop is asserted only by flush.

Decomposition:
- Package sort_pkg:
  - localparams W=8, N=5.
  - State typedef {FILL, SETUP, FIRE, GAP}.
  - Element typedef logic [W-1:0].
- One sub-module: sort_down_counter. Loadable down-counter with zero flag, reused for FIRE length, GAP length and timeout.

Test Plan:
- Reset then stream 0x30,0x10,0x50,0x20,0x40 back-to-back -> a..e=30,10,50,20,40 after 5th edge; s=1 exactly 2 cycles starting one cycle later; frame_cnt=1; in_ready=0 for 1+2+6=9 cycles.
- Hold in_valid=1 across GAP with data 0xAA -> no beat consumed until in_ready returns; next frame's a=0xAA; earlier a..e unchanged until commit.
- Send 3 beats, assert flush -> drop=1 one cycle; next 5 beats 1..5 give a..e=1..5.
- Assert rst while s=1 -> s, a..e, frame_cnt=0 immediately; in_ready=1 after release.
- Send 256 frames -> frame_cnt wraps to 0.
- With SORT_LOADER_TIMEOUT_EN: 2 beats then 16 idle cycles -> drop pulse, count=0. Without the macro: same stimulus gives no drop, and 3 more beats complete the frame.
